// File: rtl/fifo_pkg.sv
// fifo_pkg
// Shared definitions for the FIFO family (single-clock and dual-clock):
// default geometry, read-mode selectors and a constant log2 helper.
package fifo_pkg;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_DEPTH = 16;

  // Read-mode selectors for the FWFT parameter
  localparam int MODE_STD  = 0;
  localparam int MODE_FWFT = 1;

  // Ceiling log2, usable in parameter context. Returns 0 for value <= 1.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << r) < value) r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// fifo_mem
// DEPTH x WIDTH register array with one synchronous write port and one
// asynchronous (combinational) read port. Contents are not reset.
// Ports:
//   clk      - write clock
//   we_i     - write strobe
//   waddr_i  - write address
//   wdata_i  - write data
//   raddr_i  - read address
//   rdata_o  - read data, combinational from raddr_i
module fifo_mem #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic             clk,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/sync_fifo_param.sv
// sync_fifo_param
// Single-clock parametrised FIFO with occupancy count, programmable
// almost-full/almost-empty thresholds, sticky overflow/underflow flags and
// a selectable read mode (registered read or first-word-fall-through).
// Ports:
//   clk, resetn           - clock, asynchronous active-low reset
//   write_enable/data     - push request and data
//   read_enable           - pop request
//   read_data/read_valid  - popped word (std) or queue head (FWFT)
//   full/empty/almost_*   - status, decoded from the registered count
//   count                 - occupancy 0..DEPTH
//   overflow/underflow    - sticky error flags
//   clear_flags           - synchronous clear of the sticky flags
module sync_fifo_param
  import fifo_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH,
  parameter int AF_TH = DEPTH - 2,
  parameter int AE_TH = 2,
  parameter int FWFT  = MODE_STD,
  localparam int AW   = clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             write_enable,
  input  logic [WIDTH-1:0] write_data,
  input  logic             read_enable,
  output logic [WIDTH-1:0] read_data,
  output logic             read_valid,
  output logic             full_flag,
  output logic             empty_flag,
  output logic             almost_full_flag,
  output logic             almost_empty_flag,
  output logic [AW:0]      count,
  output logic             overflow_flag,
  output logic             underflow_flag,
  input  logic             clear_flags
);

  localparam logic [AW:0] FULL_C = (AW+1)'(DEPTH);
  localparam logic [AW:0] AF_C   = (AW+1)'(AF_TH);
  localparam logic [AW:0] AE_C   = (AW+1)'(AE_TH);

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic             wr_ok, rd_ok;
  logic [WIDTH-1:0] mem_rdata;

  assign full_flag         = (count_q == FULL_C);
  assign empty_flag        = (count_q == '0);
  assign almost_full_flag  = (count_q >= AF_C);
  assign almost_empty_flag = (count_q <= AE_C);
  assign count             = count_q;
  assign overflow_flag     = ovf_q;
  assign underflow_flag    = unf_q;

  // No bypass: a write into an empty FIFO is not readable in the same cycle.
  assign wr_ok = write_enable && !full_flag;
  assign rd_ok = read_enable && !empty_flag;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_ok) wr_ptr_d = wr_ptr_q + AW'(1);
    if (rd_ok) rd_ptr_d = rd_ptr_q + AW'(1);
    case ({wr_ok, rd_ok})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // A new violation wins over a same-cycle clear.
  always_comb begin
    ovf_d = ovf_q;
    unf_d = unf_q;
    if (write_enable && full_flag) ovf_d = 1'b1;
    else if (clear_flags)          ovf_d = 1'b0;
    if (read_enable && empty_flag) unf_d = 1'b1;
    else if (clear_flags)          unf_d = 1'b0;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  fifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk     (clk),
    .we_i    (wr_ok),
    .waddr_i (wr_ptr_q),
    .wdata_i (write_data),
    .raddr_i (rd_ptr_q),
    .rdata_o (mem_rdata)
  );

  if (FWFT == MODE_FWFT) begin : g_fwft
    // Head of queue is always presented; read_enable just pops it.
    assign read_data  = mem_rdata;
    assign read_valid = !empty_flag;
  end else begin : g_std
    logic [WIDTH-1:0] rd_data_q, rd_data_d;
    logic             rd_valid_q;

    assign rd_data_d = rd_ok ? mem_rdata : rd_data_q;

    always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
        rd_data_q  <= '0;
        rd_valid_q <= 1'b0;
      end else begin
        rd_data_q  <= rd_data_d;
        rd_valid_q <= rd_ok;
      end
    end

    assign read_data  = rd_data_q;
    assign read_valid = rd_valid_q;
  end

endmodule

// File: tb/tb_sync_fifo_param.sv
module tb_sync_fifo_param;

  logic clk;
  logic resetn;

  // Standard-mode instance
  logic        s_we, s_re, s_clr;
  logic [31:0] s_wd, s_rd;
  logic        s_rv, s_full, s_empty, s_af, s_ae, s_ovf, s_unf;
  logic [4:0]  s_cnt;

  // FWFT-mode instance
  logic        f_we, f_re, f_clr;
  logic [31:0] f_wd, f_rd;
  logic        f_rv, f_full, f_empty, f_af, f_ae, f_ovf, f_unf;
  logic [4:0]  f_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  sync_fifo_param #(.WIDTH(32), .DEPTH(16), .AF_TH(14), .AE_TH(2), .FWFT(0)) dut_std (
    .clk(clk), .resetn(resetn),
    .write_enable(s_we), .write_data(s_wd), .read_enable(s_re),
    .read_data(s_rd), .read_valid(s_rv), .full_flag(s_full), .empty_flag(s_empty),
    .almost_full_flag(s_af), .almost_empty_flag(s_ae), .count(s_cnt),
    .overflow_flag(s_ovf), .underflow_flag(s_unf), .clear_flags(s_clr)
  );

  sync_fifo_param #(.WIDTH(32), .DEPTH(16), .AF_TH(14), .AE_TH(2), .FWFT(1)) dut_fw (
    .clk(clk), .resetn(resetn),
    .write_enable(f_we), .write_data(f_wd), .read_enable(f_re),
    .read_data(f_rd), .read_valid(f_rv), .full_flag(f_full), .empty_flag(f_empty),
    .almost_full_flag(f_af), .almost_empty_flag(f_ae), .count(f_cnt),
    .overflow_flag(f_ovf), .underflow_flag(f_unf), .clear_flags(f_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_std_reset(input string tag);
    check({tag, "_cnt"},   64'(s_cnt),   64'd0);
    check({tag, "_empty"}, 64'(s_empty), 64'd1);
    check({tag, "_ae"},    64'(s_ae),    64'd1);
    check({tag, "_full"},  64'(s_full),  64'd0);
    check({tag, "_af"},    64'(s_af),    64'd0);
    check({tag, "_rv"},    64'(s_rv),    64'd0);
    check({tag, "_rd"},    64'(s_rd),    64'd0);
    check({tag, "_ovf"},   64'(s_ovf),   64'd0);
    check({tag, "_unf"},   64'(s_unf),   64'd0);
  endtask

  logic [31:0] exp_q[$];
  logic [31:0] exp_w;

  initial begin
    resetn = 1'b0;
    s_we = 1'b1; s_re = 1'b1; s_clr = 1'b0; s_wd = 32'hdead_beef;
    f_we = 1'b1; f_re = 1'b1; f_clr = 1'b0; f_wd = 32'hdead_beef;
    repeat (2) tick();
    check_std_reset("rst");
    check("rst_f_rv", 64'(f_rv), 64'd0);
    check("rst_f_empty", 64'(f_empty), 64'd1);

    s_we = 1'b0; s_re = 1'b0; f_we = 1'b0; f_re = 1'b0;
    resetn = 1'b1;
    tick();
    check("idle_cnt", 64'(s_cnt), 64'd0);

    // Fill 0..15
    for (int i = 0; i < 16; i++) begin
      s_we = 1'b1; s_wd = 32'(i);
      tick();
      check("fill_cnt",  64'(s_cnt),  64'(i + 1));
      check("fill_af",   64'(s_af),   64'((i + 1) >= 14));
      check("fill_full", 64'(s_full), 64'((i + 1) == 16));
      check("fill_ae",   64'(s_ae),   64'((i + 1) <= 2));
      check("fill_rv",   64'(s_rv),   64'd0);
    end

    // Write while full
    s_wd = 32'd99;
    tick();
    s_we = 1'b0;
    check("ovf_set",  64'(s_ovf),  64'd1);
    check("ovf_cnt",  64'(s_cnt),  64'd16);
    check("ovf_full", 64'(s_full), 64'd1);

    // Drain, expecting 0..15 one cycle after each request
    for (int i = 0; i < 16; i++) begin
      s_re = 1'b1;
      tick();
      check("drain_rv",   64'(s_rv), 64'd1);
      check("drain_data", 64'(s_rd), 64'(i));
      check("drain_cnt",  64'(s_cnt), 64'(15 - i));
    end
    check("drain_empty", 64'(s_empty), 64'd1);

    // Read while empty: rejected, underflow set, data holds
    tick();
    s_re = 1'b0;
    check("unf_set",  64'(s_unf), 64'd1);
    check("unf_rv",   64'(s_rv),  64'd0);
    check("unf_hold", 64'(s_rd),  64'd15);
    check("unf_cnt",  64'(s_cnt), 64'd0);
    check("ovf_sticky", 64'(s_ovf), 64'd1);

    s_clr = 1'b1;
    tick();
    check("clr_ovf", 64'(s_ovf), 64'd0);
    check("clr_unf", 64'(s_unf), 64'd0);

    // Clear together with a new underflow: set wins
    s_re = 1'b1;
    tick();
    s_re = 1'b0;
    check("clrset_unf", 64'(s_unf), 64'd1);
    check("clrset_ovf", 64'(s_ovf), 64'd0);
    tick();
    s_clr = 1'b0;
    check("clr2_unf", 64'(s_unf), 64'd0);

    // Simultaneous read/write at count 5
    for (int i = 0; i < 5; i++) begin
      s_we = 1'b1; s_wd = 32'(100 + i);
      tick();
    end
    check("sim_pre_cnt", 64'(s_cnt), 64'd5);
    for (int k = 0; k < 10; k++) begin
      s_we = 1'b1; s_re = 1'b1; s_wd = 32'(105 + k);
      tick();
      check("sim_cnt",  64'(s_cnt), 64'd5);
      check("sim_rv",   64'(s_rv),  64'd1);
      check("sim_data", 64'(s_rd),  64'(100 + k));
    end
    s_we = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      check("sim_tail", 64'(s_rd), 64'(110 + k));
    end
    s_re = 1'b0;
    tick();
    check("sim_empty", 64'(s_empty), 64'd1);

    // Simultaneous at full: read accepted, write rejected
    for (int i = 0; i < 16; i++) begin
      s_we = 1'b1; s_wd = 32'(200 + i);
      tick();
    end
    s_we = 1'b1; s_re = 1'b1; s_wd = 32'd77;
    tick();
    s_we = 1'b0;
    check("fullrw_cnt",  64'(s_cnt), 64'd15);
    check("fullrw_ovf",  64'(s_ovf), 64'd1);
    check("fullrw_data", 64'(s_rd),  64'd200);
    for (int i = 1; i < 16; i++) begin
      tick();
      check("fullrw_drain", 64'(s_rd), 64'(200 + i));
    end
    s_re = 1'b0; s_clr = 1'b1;
    tick();
    s_clr = 1'b0;
    check("fullrw_empty", 64'(s_empty), 64'd1);
    check("fullrw_clr",   64'(s_ovf),   64'd0);

    // Wrap-around: count swings 0..16 twice plus a mixed phase
    exp_w = 32'h300;
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 16; i++) begin
        s_we = 1'b1; s_wd = exp_w; exp_q.push_back(exp_w); exp_w++;
        tick();
      end
      s_we = 1'b0;
      check("wrap_full", 64'(s_full), 64'd1);
      for (int i = 0; i < 16; i++) begin
        s_re = 1'b1;
        tick();
        check("wrap_data", 64'(s_rd), 64'(exp_q.pop_front()));
      end
      s_re = 1'b0;
      check("wrap_empty", 64'(s_empty), 64'd1);
    end
    for (int i = 0; i < 8; i++) begin
      s_we = 1'b1; s_re = (i % 2) == 1; s_wd = exp_w; exp_q.push_back(exp_w); exp_w++;
      tick();
      if (i % 2 == 1) check("wrap_mix", 64'(s_rd), 64'(exp_q.pop_front()));
    end
    s_we = 1'b0; s_re = 1'b0;
    tick();
    check("wrap_mix_cnt", 64'(s_cnt), 64'(exp_q.size()));

    // FWFT instance
    f_we = 1'b1; f_wd = 32'd7;
    tick();
    f_we = 1'b0;
    check("fw_data", 64'(f_rd),  64'd7);
    check("fw_rv",   64'(f_rv),  64'd1);
    check("fw_cnt",  64'(f_cnt), 64'd1);
    f_re = 1'b1;
    tick();
    f_re = 1'b0;
    check("fw_pop_empty", 64'(f_empty), 64'd1);
    check("fw_pop_rv",    64'(f_rv),    64'd0);
    for (int i = 0; i < 9; i++) begin
      f_we = 1'b1; f_wd = 32'(10 + i);
      tick();
    end
    f_we = 1'b0;
    check("fw_cnt9",  64'(f_cnt), 64'd9);
    check("fw_head",  64'(f_rd),  64'd10);
    f_re = 1'b1;
    tick();
    f_re = 1'b0;
    check("fw_head2", 64'(f_rd),  64'd11);
    check("fw_cnt8",  64'(f_cnt), 64'd8);

    // Asynchronous reset mid-operation, checked between edges
    s_we = 1'b1; s_wd = 32'd5;
    tick();
    s_we = 1'b0; s_re = 1'b1;
    tick();
    s_re = 1'b0;
    check("pre_rst_rv", 64'(s_rv), 64'd1);
    #2;
    resetn = 1'b0;
    #1;
    check("arst_f_cnt",   64'(f_cnt),   64'd0);
    check("arst_f_rv",    64'(f_rv),    64'd0);
    check("arst_f_empty", 64'(f_empty), 64'd1);
    check("arst_f_ae",    64'(f_ae),    64'd1);
    check_std_reset("arst");
    tick();
    resetn = 1'b1;
    tick();
    check("post_rst_cnt", 64'(s_cnt), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
